// File: rtl/pipeline_pkg.sv
// Shared LEGv8 pipeline control definitions.
// Opcode constants, controller states and the zero-register index.
package pipeline_pkg;

  localparam logic [10:0] OP_LDUR = 11'b111_1100_0010;
  localparam logic [10:0] OP_STUR = 11'b111_1100_0000;
  localparam logic [7:0]  OP_CBZ  = 8'b1011_0100;

  localparam int ZR_IDX = 31;

  typedef enum logic [1:0] {
    BOOT,
    RUN,
    STALL,
    FREEZE
  } ctrl_state_t;

endpackage

// File: rtl/hazard_decode.sv
// Decodes the IF/ID instruction and flags a load-use hazard
// against the instruction shadowed in ID/EX.
module hazard_decode #(
  parameter int ZR_IDX = pipeline_pkg::ZR_IDX
) (
  input  logic [31:0] id_instr,
  input  logic [4:0]  ex_rd,
  input  logic        ex_memread,
  input  logic        ex_valid,
  input  logic        id_valid,
  output logic        hz,
  output logic        dec_memread,
  output logic [4:0]  dec_rd
);
  import pipeline_pkg::*;

  logic       w_is_ldur;
  logic       w_is_stur;
  logic       w_is_cbz;
  logic       w_use_rn;
  logic       w_use_rm;
  logic       w_use_rt;
  logic       w_hit;
  logic [4:0] w_rn;
  logic [4:0] w_rm;
  logic [4:0] w_rt;

  assign w_is_ldur = (id_instr[31:21] == OP_LDUR);
  assign w_is_stur = (id_instr[31:21] == OP_STUR);
  assign w_is_cbz  = (id_instr[31:24] == OP_CBZ);
  assign w_rn      = id_instr[9:5];
  assign w_rm      = id_instr[20:16];
  assign w_rt      = id_instr[4:0];

  always_comb begin
    w_use_rn = 1'b1;
    w_use_rm = 1'b0;
    w_use_rt = 1'b0;
    unique case (1'b1)
      w_is_ldur: begin
        w_use_rn = 1'b1;
      end
      w_is_stur: begin
        w_use_rn = 1'b1;
        w_use_rt = 1'b1;
      end
      w_is_cbz: begin
        w_use_rn = 1'b0;
        w_use_rt = 1'b1;
      end
      default: begin
        w_use_rn = 1'b1;
        w_use_rm = 1'b1;
      end
    endcase
  end

  assign w_hit = (w_use_rn && (w_rn == ex_rd))
              || (w_use_rm && (w_rm == ex_rd))
              || (w_use_rt && (w_rt == ex_rd));

  // XZR reads as zero, so a load into it never feeds anyone
  assign hz = id_valid && ex_valid && ex_memread
           && (ex_rd != 5'(ZR_IDX)) && w_hit;

  assign dec_memread = w_is_ldur;
  assign dec_rd      = id_instr[4:0];

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// 5-stage LEGv8 pipeline sequencer: advance, load-use stall,
// branch flush and external freeze, with saturating event counters.
module pipeline_hazard_ctrl #(
  parameter int CNT_W  = 16,
  parameter int ZR_IDX = pipeline_pkg::ZR_IDX
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      id_instr,
  input  logic             mem_pcsrc,
  input  logic             ext_stall,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             id_ex_bubble,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             ex_mem_flush,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);
  import pipeline_pkg::*;

  ctrl_state_t      r_state;
  ctrl_state_t      w_nxt;
  logic             r_id_valid;
  logic             r_ex_valid;
  logic             r_ex_memread;
  logic [4:0]       r_ex_rd;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;

  logic             w_hz;
  logic             w_dec_memread;
  logic [4:0]       w_dec_rd;
  logic             w_adv;
  logic             w_flush;
  logic             w_stall;
  logic             w_fl;

  hazard_decode #(
    .ZR_IDX(ZR_IDX)
  ) u_dec (
    .id_instr   (id_instr),
    .ex_rd      (r_ex_rd),
    .ex_memread (r_ex_memread),
    .ex_valid   (r_ex_valid),
    .id_valid   (r_id_valid),
    .hz         (w_hz),
    .dec_memread(w_dec_memread),
    .dec_rd     (w_dec_rd)
  );

  always_comb begin
    w_nxt        = r_state;
    pc_write     = 1'b1;
    if_id_write  = 1'b1;
    id_ex_bubble = 1'b0;
    w_fl         = 1'b0;
    w_adv        = 1'b0;
    w_flush      = 1'b0;
    w_stall      = 1'b0;
    if (r_state == BOOT) begin
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      w_fl        = 1'b1;
      w_nxt       = RUN;
    end else if (ext_stall) begin
      // a pending branch stays parked upstream until the freeze ends
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      w_nxt       = FREEZE;
    end else if (mem_pcsrc) begin
      w_fl    = 1'b1;
      w_flush = 1'b1;
      w_nxt   = RUN;
    end else if (w_hz) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      id_ex_bubble = 1'b1;
      w_stall      = 1'b1;
      w_nxt        = STALL;
    end else begin
      w_adv = 1'b1;
      w_nxt = RUN;
    end
  end

  assign if_id_flush  = w_fl;
  assign id_ex_flush  = w_fl;
  assign ex_mem_flush = w_fl;
  assign stall_count  = r_stall_cnt;
  assign flush_count  = r_flush_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= BOOT;
      r_id_valid   <= 1'b0;
      r_ex_valid   <= 1'b0;
      r_ex_memread <= 1'b0;
      r_ex_rd      <= 5'd0;
      r_stall_cnt  <= '0;
      r_flush_cnt  <= '0;
    end else begin
      r_state <= w_nxt;
      if (w_flush) begin
        r_id_valid <= 1'b0;
        r_ex_valid <= 1'b0;
        if (r_flush_cnt != '1)
          r_flush_cnt <= r_flush_cnt + 1'b1;
      end
      if (w_stall) begin
        r_ex_valid <= 1'b0;
        if (r_stall_cnt != '1)
          r_stall_cnt <= r_stall_cnt + 1'b1;
      end
      if (w_adv) begin
        r_ex_valid   <= r_id_valid;
        r_ex_memread <= w_dec_memread;
        r_ex_rd      <= w_dec_rd;
        r_id_valid   <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl.
// A second instance with CNT_W=2 shares the stimulus to show saturation.
module tb_pipeline_hazard_ctrl;

  localparam logic [5:0] C_ADV  = 6'b110000;
  localparam logic [5:0] C_BOOT = 6'b000111;
  localparam logic [5:0] C_HZ   = 6'b001000;
  localparam logic [5:0] C_FL   = 6'b110111;
  localparam logic [5:0] C_FRZ  = 6'b000000;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] id_instr;
  logic        mem_pcsrc;
  logic        ext_stall;

  logic        pc_write, if_id_write, id_ex_bubble;
  logic        if_id_flush, id_ex_flush, ex_mem_flush;
  logic [15:0] stall_count, flush_count;

  logic        pc_write2, if_id_write2, id_ex_bubble2;
  logic        if_id_flush2, id_ex_flush2, ex_mem_flush2;
  logic [1:0]  stall_count2, flush_count2;

  int n_run  = 0;
  int n_fail = 0;

  pipeline_hazard_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .id_instr    (id_instr),
    .mem_pcsrc   (mem_pcsrc),
    .ext_stall   (ext_stall),
    .pc_write    (pc_write),
    .if_id_write (if_id_write),
    .id_ex_bubble(id_ex_bubble),
    .if_id_flush (if_id_flush),
    .id_ex_flush (id_ex_flush),
    .ex_mem_flush(ex_mem_flush),
    .stall_count (stall_count),
    .flush_count (flush_count)
  );

  pipeline_hazard_ctrl #(.CNT_W(2)) dut2 (
    .clk         (clk),
    .reset       (reset),
    .id_instr    (id_instr),
    .mem_pcsrc   (mem_pcsrc),
    .ext_stall   (ext_stall),
    .pc_write    (pc_write2),
    .if_id_write (if_id_write2),
    .id_ex_bubble(id_ex_bubble2),
    .if_id_flush (if_id_flush2),
    .id_ex_flush (id_ex_flush2),
    .ex_mem_flush(ex_mem_flush2),
    .stall_count (stall_count2),
    .flush_count (flush_count2)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ldur(input logic [4:0] rt,
                                       input logic [4:0] rn);
    return {11'b111_1100_0010, 9'd0, 2'b00, rn, rt};
  endfunction

  function automatic logic [31:0] stur(input logic [4:0] rt,
                                       input logic [4:0] rn);
    return {11'b111_1100_0000, 9'd0, 2'b00, rn, rt};
  endfunction

  function automatic logic [31:0] cbz(input logic [4:0] rt);
    return {8'b1011_0100, 19'd0, rt};
  endfunction

  function automatic logic [31:0] add(input logic [4:0] rd,
                                      input logic [4:0] rn,
                                      input logic [4:0] rm);
    return {11'b100_0101_1000, rm, 6'd0, rn, rd};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_run++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic ctl(input string tag, input logic [5:0] exp);
    chk(tag, {26'd0, pc_write, if_id_write, id_ex_bubble,
              if_id_flush, id_ex_flush, ex_mem_flush},
        {26'd0, exp});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] ins, input logic br,
                       input logic st);
    id_instr  = ins;
    mem_pcsrc = br;
    ext_stall = st;
    #1;
  endtask

  initial begin
    reset     = 1'b1;
    id_instr  = add(31, 31, 31);
    mem_pcsrc = 1'b0;
    ext_stall = 1'b0;
    #2;
    ctl("rst_ctl", C_BOOT);
    chk("rst_sc", 32'(stall_count), 0);
    chk("rst_fc", 32'(flush_count), 0);
    step();
    step();
    reset = 1'b0;
    #1;
    ctl("boot_ctl", C_BOOT);

    step(); drive(add(31, 31, 31), 0, 0);
    ctl("run1_ctl", C_ADV);
    chk("run1_sc", 32'(stall_count), 0);

    step(); drive(ldur(1, 2), 0, 0);
    ctl("ld_ctl", C_ADV);
    step(); drive(add(3, 1, 4), 0, 0);
    ctl("lu_add", C_HZ);
    chk("lu_sc0", 32'(stall_count), 0);
    step(); #1;
    ctl("lu_add_next", C_ADV);
    chk("lu_sc1", 32'(stall_count), 1);

    step(); drive(ldur(1, 2), 0, 0);
    step(); drive(stur(1, 5), 0, 0);
    ctl("lu_stur", C_HZ);
    step(); #1;
    ctl("lu_stur_next", C_ADV);

    step(); drive(ldur(1, 2), 0, 0);
    step(); drive(cbz(1), 0, 0);
    ctl("lu_cbz", C_HZ);
    step(); #1;
    ctl("lu_cbz_next", C_ADV);

    step(); drive(ldur(31, 2), 0, 0);
    step(); drive(add(3, 31, 4), 0, 0);
    ctl("zr_nohz", C_ADV);

    step(); drive(ldur(1, 2), 0, 0);
    step(); drive(add(3, 2, 4), 0, 0);
    ctl("nomatch", C_ADV);
    chk("sc3", 32'(stall_count), 3);
    chk("sc3_w2", 32'(stall_count2), 3);

    step(); drive(ldur(1, 2), 0, 0);
    step(); drive(add(3, 1, 4), 1, 0);
    ctl("br_hz", C_FL);
    step(); drive(add(3, 1, 4), 0, 0);
    ctl("post_br", C_ADV);
    chk("br_fc1", 32'(flush_count), 1);
    chk("br_sc", 32'(stall_count), 3);

    for (int i = 0; i < 3; i++) begin
      step(); drive(add(31, 31, 31), 1, 1);
      ctl($sformatf("frz%0d", i), C_FRZ);
    end
    chk("frz_fc", 32'(flush_count), 1);
    step(); drive(add(31, 31, 31), 1, 0);
    ctl("unfrz", C_FL);
    step(); drive(add(31, 31, 31), 0, 0);
    ctl("unfrz_next", C_ADV);
    chk("frz_fc2", 32'(flush_count), 2);

    for (int i = 0; i < 2; i++) begin
      step(); drive(ldur(1, 2), 0, 0);
      step(); drive(add(3, 1, 4), 0, 0);
      ctl($sformatf("sat_hz%0d", i), C_HZ);
      step(); #1;
    end
    chk("sat_sc16", 32'(stall_count), 5);
    chk("sat_sc2", 32'(stall_count2), 3);

    step(); drive(ldur(1, 2), 0, 0);
    step(); drive(add(3, 1, 4), 0, 0);
    ctl("pre_rst", C_HZ);
    #2;
    reset = 1'b1;
    #1;
    ctl("mid_rst", C_BOOT);
    chk("mid_rst_sc", 32'(stall_count), 0);
    chk("mid_rst_fc", 32'(flush_count), 0);
    chk("mid_rst_sc2", 32'(stall_count2), 0);
    step();
    reset = 1'b0;
    #1;
    ctl("reboot", C_BOOT);
    step(); #1;
    ctl("rerun", C_ADV);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
